start_screen_ctrl: RTL
======================

Name: start_screen_ctrl

Overview:
Sequencing controller that drives the start-screen renderer: it supplies the standBy blink phase the title/key/credit bitmaps consume, and it decides when the start screen is shown. It accepts raw key levels (credit insert, start), keeps a credit count, fires a one-cycle game-start pulse to the game core, and returns to the start screen on game over. It sits between the keypad decoder and the start-screen/game muxes, clocked on the pixel clock.

Parameters:
BLINK_FRAMES, 30, number of startOfFrame pulses per standBy half-period
LOCKOUT_FRAMES, 8, frames a key is ignored after an accepted press (debounce)
MAX_CREDITS, 9, saturation value of credit counter
OVER_HOLD_FRAMES, 120, frames in GAME_OVER before returning to the start screen

Ports:
clk  in  1  pixel clock
resetN  in  1  asynchronous reset, active-high (asserted = 1) despite the name
startOfFrame  in  1  one-cycle pulse per video frame
keyStart  in  1  raw start-key level, asynchronous to clk
keyCredit  in  1  raw credit-key level, asynchronous to clk
gameOver  in  1  one-cycle pulse from game core
standBy  out  1  blink phase to the start-screen bitmaps
showStartScreen  out  1  1 = start-screen layer enabled in the top mux
gameStartPulse  out  1  one-cycle pulse that starts a game
credits  out  4  current credit count, 0..MAX_CREDITS

Behaviour:
- Reset values: state ATTRACT, standBy 0, showStartScreen 1, gameStartPulse 0, credits 0, all counters and lockouts 0, synchronizers 0.
- Key input path: each key goes through a 2-FF synchronizer, then a rising-edge detect on the synchronized level.
- Key acceptance: an edge is accepted only when that key's lockout counter is 0. Acceptance loads the lockout with LOCKOUT_FRAMES, which then decrements on each startOfFrame.
- Key latency: an input rise that is stable before clk edge N is accepted at edge N+3.
- Credit key: accepted in every state, including PLAYING. It increments credits and saturates at MAX_CREDITS; a press at MAX is dropped.
- States:
  - ATTRACT (credits==0): showStartScreen=1, blink runs. Go to READY when credits becomes non-zero.
  - READY (credits>0): showStartScreen=1, blink runs. An accepted start decrements credits and moves to LAUNCH. Start presses in ATTRACT are ignored.
  - LAUNCH: one cycle. gameStartPulse=1 registered in this cycle, showStartScreen=0. Next state is PLAYING.
  - PLAYING: showStartScreen=0, standBy=0, blink counter held at 0. Start presses are ignored. gameOver moves to GAME_OVER.
  - GAME_OVER: showStartScreen=1, standBy forced 1. After OVER_HOLD_FRAMES startOfFrame pulses, go to READY if credits>0, else ATTRACT. A start press in GAME_OVER is ignored.
- Blink: in ATTRACT/READY, a frame counter counts startOfFrame pulses. At BLINK_FRAMES-1 it wraps to 0 and toggles standBy. On entry to ATTRACT/READY from GAME_OVER the counter restarts at 0 with standBy=0. The ATTRACT<->READY transition does not disturb the blink.
- Simultaneous credit and start accepted in READY: the start decision uses the pre-cycle credits value. The counter update is credits - 1 + 1, so net unchanged (including at MAX). In ATTRACT the credit is counted, the start is ignored, and the next state is READY.
- gameOver outside PLAYING is ignored.
- Frame counter widths are sized with $clog2 of the parameter+1. credits arithmetic is 4-bit unsigned; it never underflows because a decrement requires credits>0.
- Asynchronous reset at any time, including mid-LAUNCH, forces all reset values within the same cycle; gameStartPulse drops immediately.

Decomposition:
- Shared package start_screen_pkg holds:
  - enum typedef ss_state_t {ATTRACT, READY, LAUNCH, PLAYING, GAME_OVER};
  - localparam CREDIT_W=4.
- Sub-module key_press_filter (2-FF sync + edge detect + frame lockout; param LOCKOUT_FRAMES; outputs a one-cycle pressAccepted), instantiated twice.

Test Plan:
1. Reset, then 65 frames with no keys -> state ATTRACT, credits 0, showStartScreen 1, standBy toggles at frames 30 and 60, gameStartPulse never high.
2. keyCredit held high 20 frames, then low, then high again 10 frames later -> credits=2 (one press per rise, no bounce counting); state READY by cycle N+4 after the first rise.
3. credits=1, keyStart rise -> gameStartPulse high exactly one cycle 4 clocks after the rise; credits=0; showStartScreen 0; standBy 0 while PLAYING.
4. PLAYING, gameOver pulse, credits=0 -> GAME_OVER with standBy 1 for 120 frames, then ATTRACT with standBy 0 and blink restarting.
5. credits=9 in READY, keyCredit and keyStart accepted on the same cycle -> one gameStartPulse, credits stays 9; a further credit press in PLAYING (credits 9) -> stays 9.
6. Assert resetN one cycle during LAUNCH -> gameStartPulse low immediately, credits 0, state ATTRACT, showStartScreen 1.

Source files
------------

// File: rtl/start_screen_pkg.sv
// Shared types and constants for the start-screen sequencing controller.
//   ss_state_t : top-level sequencing states
//   CREDIT_W   : width of the credit counter
package start_screen_pkg;

  typedef enum logic [2:0] {
    ATTRACT,
    READY,
    LAUNCH,
    PLAYING,
    GAME_OVER
  } ss_state_t;

  localparam int CREDIT_W = 4;

endpackage

// File: rtl/key_press_filter.sv
// Key press filter: 2-FF synchronizer, rising-edge detect and a frame-based
// lockout that swallows contact bounce after an accepted press.
// Ports:
//   clk                : pixel clock
//   rst                : asynchronous reset, active-high
//   key_i              : raw key level, asynchronous to clk
//   start_of_frame_i   : one-cycle pulse per video frame (lockout time base)
//   press_accepted_o   : one-cycle pulse, registered, for each accepted press
// A rise stable before edge N shows up on press_accepted_o after edge N+2,
// so the consumer acts on it at edge N+3.
module key_press_filter #(
  parameter int LOCKOUT_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic start_of_frame_i,
  output logic press_accepted_o
);

  localparam int LOCK_W = $clog2(LOCKOUT_FRAMES + 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              prev_q;
  logic              press_q;
  logic [LOCK_W-1:0] lock_q;
  logic [LOCK_W-1:0] lock_d;
  logic              rise;
  logic              accept;

  assign rise   = sync2_q & ~prev_q;
  assign accept = rise && (lock_q == '0);

  // NOTE: every signal written here gets its default first, so no path
  // leaves lock_d unassigned and no latch is inferred.
  always_comb begin
    lock_d = lock_q;
    if (accept) begin
      lock_d = LOCK_W'(LOCKOUT_FRAMES);
    end else if (start_of_frame_i && (lock_q != '0)) begin
      lock_d = lock_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which the synchronizer chain needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      lock_q  <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= accept;
      lock_q  <= lock_d;
    end
  end

  assign press_accepted_o = press_q;

endmodule

// File: rtl/start_screen_ctrl.sv
// Start-screen sequencing controller.
// Produces the standBy blink phase for the start-screen bitmaps, decides when
// the start screen is shown, keeps the credit count and fires a one-cycle
// game-start pulse towards the game core.
// Ports:
//   clk             : pixel clock
//   resetN          : asynchronous reset, active-high despite the name
//   startOfFrame    : one-cycle pulse per video frame
//   keyStart        : raw start-key level (asynchronous)
//   keyCredit       : raw credit-key level (asynchronous)
//   gameOver        : one-cycle pulse from the game core
//   standBy         : blink phase to the start-screen bitmaps
//   showStartScreen : 1 = start-screen layer enabled in the top mux
//   gameStartPulse  : one-cycle pulse that starts a game
//   credits         : current credit count, 0..MAX_CREDITS
module start_screen_ctrl
  import start_screen_pkg::*;
#(
  parameter int BLINK_FRAMES     = 30,
  parameter int LOCKOUT_FRAMES   = 8,
  parameter int MAX_CREDITS      = 9,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                keyStart,
  input  logic                keyCredit,
  input  logic                gameOver,
  output logic                standBy,
  output logic                showStartScreen,
  output logic                gameStartPulse,
  output logic [CREDIT_W-1:0] credits
);

  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int HOLD_W  = $clog2(OVER_HOLD_FRAMES + 1);

  ss_state_t           state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [CREDIT_W-1:0] credits_base;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                start_acc;
  logic                credit_acc;
  logic                start_take;
  logic                blink_active;

  key_press_filter #(
    .LOCKOUT_FRAMES(LOCKOUT_FRAMES)
  ) u_start_filter (
    .clk              (clk),
    .rst              (resetN),
    .key_i            (keyStart),
    .start_of_frame_i (startOfFrame),
    .press_accepted_o (start_acc)
  );

  key_press_filter #(
    .LOCKOUT_FRAMES(LOCKOUT_FRAMES)
  ) u_credit_filter (
    .clk              (clk),
    .rst              (resetN),
    .key_i            (keyCredit),
    .start_of_frame_i (startOfFrame),
    .press_accepted_o (credit_acc)
  );

  // Start only counts in READY; the decision uses the pre-cycle credit value.
  assign start_take   = (state_q == READY) && start_acc && (credits_q != '0);
  assign blink_active = (state_q == ATTRACT) || (state_q == READY);

  always_comb begin
    // Decrement first, then saturate the increment against the decremented
    // value, so start+credit together at MAX nets to no change.
    credits_base = credits_q - CREDIT_W'(start_take);
    credits_d    = credits_base;
    if (credit_acc && (credits_base < CREDIT_W'(MAX_CREDITS))) begin
      credits_d = credits_base + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    unique case (state_q)
      ATTRACT: begin
        if (credits_d != '0) state_d = READY;
      end
      READY: begin
        if (start_take) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = PLAYING;
      end
      PLAYING: begin
        if (gameOver) state_d = GAME_OVER;
      end
      GAME_OVER: begin
        hold_cnt_d = hold_cnt_q;
        if (startOfFrame) begin
          if (hold_cnt_q == HOLD_W'(OVER_HOLD_FRAMES - 1)) begin
            hold_cnt_d = '0;
            state_d    = (credits_d != '0) ? READY : ATTRACT;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ATTRACT;
      end
    endcase
  end

  // Blink runs only while idling on the start screen; every other state parks
  // it at phase 0 so re-entry from GAME_OVER restarts a clean half-period.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (blink_active) begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (startOfFrame) begin
        if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q     <= ATTRACT;
      credits_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign showStartScreen = (state_q == ATTRACT) || (state_q == READY) ||
                           (state_q == GAME_OVER);
  assign standBy         = (state_q == GAME_OVER) ? 1'b1 :
                           (blink_active ? blink_q : 1'b0);
  assign gameStartPulse  = (state_q == LAUNCH);
  assign credits         = credits_q;

endmodule
